// File: rtl/ntt_stage_sequencer.sv
// NTT DIF stage sequencer: one butterfly beat per valid&&ready, PIPE_LAT-cycle drain between stages,
// start->done = S*(N/2+PIPE_LAT)+1 with ready high. NTT_SEQ_STALL_CNT_EN adds o_stall_cycles.
module ntt_stage_sequencer #(
   parameter int PIPE_LAT = 6,
   parameter int ADDR_W   = 10
) (
   input  logic              clk,
   input  logic              i_resetn,
   input  logic              i_start,
   input  logic [2:0]        i_point_cfg,
   output logic              o_bf_valid,
   input  logic              i_bf_ready,
   output logic [ADDR_W-1:0] o_addr_a,
   output logic [ADDR_W-1:0] o_addr_b,
   output logic [8:0]        o_tw_idx,
   output logic [3:0]        o_stage,
   output logic              o_stage_start,
   output logic              o_busy,
   output logic              o_done
`ifdef NTT_SEQ_STALL_CNT_EN
   ,
   output logic [15:0]       o_stall_cycles
`endif
);

   localparam int AW1 = ADDR_W + 1;
   localparam int DW  = $clog2(PIPE_LAT + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   state_t            state, state_nxt;
   logic [2:0]        cfg, cfg_nxt;
   logic [3:0]        stage, stage_nxt;
   logic [ADDR_W-1:0] k, k_nxt;
   logic [ADDR_W-1:0] base, base_nxt;
   logic [9:0]        beat, beat_nxt;
   logic [DW-1:0]     drain_cnt;
   logic [AW1-1:0]    npts;
   logic [ADDR_W-1:0] half, half_nxt;
   logic              accept, last_beat, last_stage, drain_end;

   assign npts       = AW1'(8) << cfg;
   assign half       = ADDR_W'(npts >> (stage + 4'd1));
   assign half_nxt   = ADDR_W'((AW1'(8) << cfg_nxt) >> (stage_nxt + 4'd1));
   assign accept     = o_bf_valid && i_bf_ready;
   assign last_beat  = (beat == 10'((npts >> 1) - AW1'(1)));
   assign last_stage = (stage == ({1'b0, cfg} + 4'd2));
   assign drain_end  = (drain_cnt == DW'(1));
   assign o_stage    = stage;

   always_ff @(posedge clk) begin
      if (!i_resetn) state <= IDLE;
      else           state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (i_start) state_nxt = ISSUE;
         ISSUE:   if (accept && last_beat) state_nxt = DRAIN;
         DRAIN:   if (drain_end) state_nxt = last_stage ? DONE : ISSUE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      o_bf_valid = (state == ISSUE);
      o_busy     = (state != IDLE);
      o_done     = (state == DONE);
   end

   // k walks within a butterfly group, base jumps by 2h at group end: a = base + k.
   always_comb begin
      cfg_nxt   = cfg;
      stage_nxt = stage;
      k_nxt     = k;
      base_nxt  = base;
      beat_nxt  = beat;
      case (state)
         IDLE: begin
            if (i_start) begin
               cfg_nxt   = i_point_cfg;
               stage_nxt = 4'd0;
               k_nxt     = '0;
               base_nxt  = '0;
               beat_nxt  = '0;
            end
         end
         ISSUE: begin
            if (accept && !last_beat) begin
               beat_nxt = beat + 10'd1;
               if (k == half - ADDR_W'(1)) begin
                  k_nxt    = '0;
                  base_nxt = base + ADDR_W'({half, 1'b0});
               end else begin
                  k_nxt = k + ADDR_W'(1);
               end
            end
         end
         DRAIN: begin
            if (drain_end && !last_stage) begin
               stage_nxt = stage + 4'd1;
               k_nxt     = '0;
               base_nxt  = '0;
               beat_nxt  = '0;
            end
         end
         DONE:    stage_nxt = 4'd0;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!i_resetn) begin
         cfg   <= '0;
         stage <= '0;
         k     <= '0;
         base  <= '0;
         beat  <= '0;
      end else begin
         cfg   <= cfg_nxt;
         stage <= stage_nxt;
         k     <= k_nxt;
         base  <= base_nxt;
         beat  <= beat_nxt;
      end
   end

   // Beat outputs are built from next-state values so they are registered and hold during stalls.
   always_ff @(posedge clk) begin
      if (!i_resetn) begin
         o_addr_a      <= '0;
         o_addr_b      <= '0;
         o_tw_idx      <= '0;
         o_stage_start <= 1'b0;
      end else begin
         o_stage_start <= (state_nxt == ISSUE) && (state != ISSUE);
         if (state_nxt == ISSUE) begin
            o_addr_a <= base_nxt + k_nxt;
            o_addr_b <= base_nxt + k_nxt + half_nxt;
            o_tw_idx <= 9'(k_nxt << stage_nxt);
         end else begin
            o_addr_a <= '0;
            o_addr_b <= '0;
            o_tw_idx <= '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!i_resetn)                               drain_cnt <= '0;
      else if (state == ISSUE && state_nxt == DRAIN) drain_cnt <= DW'(PIPE_LAT);
      else if (state == DRAIN && !drain_end)         drain_cnt <= drain_cnt - DW'(1);
   end

`ifdef NTT_SEQ_STALL_CNT_EN
   always_ff @(posedge clk) begin
      if (!i_resetn)                         o_stall_cycles <= '0;
      else if (state == IDLE && i_start)     o_stall_cycles <= '0;
      else if (o_bf_valid && !i_bf_ready && o_stall_cycles != 16'hFFFF)
         o_stall_cycles <= o_stall_cycles + 16'd1;
   end
`endif

endmodule

// File: tb/tb_ntt_stage_sequencer.sv
// Directed bench for ntt_stage_sequencer; expected beats come from hand tables and a div/mod reference.
module tb_ntt_stage_sequencer;

   logic       clk = 1'b0;
   logic       i_resetn, i_start, i_bf_ready;
   logic [2:0] i_point_cfg;
   logic       o_bf_valid, o_stage_start, o_busy, o_done;
   logic [9:0] o_addr_a, o_addr_b;
   logic [8:0] o_tw_idx;
   logic [3:0] o_stage;
`ifdef NTT_SEQ_STALL_CNT_EN
   logic [15:0] o_stall_cycles;
`endif

   int checks = 0;
   int errors = 0;

   ntt_stage_sequencer #(.PIPE_LAT(6), .ADDR_W(10)) dut (
      .clk(clk), .i_resetn(i_resetn), .i_start(i_start), .i_point_cfg(i_point_cfg),
      .o_bf_valid(o_bf_valid), .i_bf_ready(i_bf_ready), .o_addr_a(o_addr_a), .o_addr_b(o_addr_b),
      .o_tw_idx(o_tw_idx), .o_stage(o_stage), .o_stage_start(o_stage_start),
      .o_busy(o_busy), .o_done(o_done)
`ifdef NTT_SEQ_STALL_CNT_EN
      , .o_stall_cycles(o_stall_cycles)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int half_of(int cfg, int s);
      return (8 << cfg) >> (s + 1);
   endfunction

   function automatic logic [32:0] exp_beat(int cfg, int s, int j);
      int h, a;
      h = half_of(cfg, s);
      a = (j / h) * 2 * h + (j % h);
      return {4'(s), 10'(a), 10'(a + h), 9'((j % h) << s)};
   endfunction

   task automatic start_run(input logic [2:0] cfg);
      i_point_cfg = cfg;
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
   endtask

   task automatic test_reset();
      i_resetn = 1'b0; i_start = 1'b0; i_bf_ready = 1'b0; i_point_cfg = 3'd0;
      tick(); tick();
      checks++;
      if ({o_bf_valid, o_busy, o_done, o_stage_start, o_stage, o_addr_a, o_addr_b, o_tw_idx} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got %h required 0",
                  {o_bf_valid, o_busy, o_done, o_stage_start, o_stage, o_addr_a, o_addr_b, o_tw_idx});
      end
`ifdef NTT_SEQ_STALL_CNT_EN
      checks++;
      if (o_stall_cycles !== 16'd0) begin
         errors++; $display("FAIL reset_stall: got %0d required 0", o_stall_cycles);
      end
`endif
      i_resetn = 1'b1;
      tick();
      checks++;
      if (o_busy !== 1'b0 || o_bf_valid !== 1'b0) begin
         errors++; $display("FAIL reset_idle: busy %b valid %b required 0 0", o_busy, o_bf_valid);
      end
   endtask

   task automatic test_cfg0();
      logic [9:0] ta [12];
      logic [9:0] tb [12];
      logic [8:0] tt [12];
      int lat, bi;
      ta = '{0, 1, 2, 3, 0, 1, 4, 5, 0, 2, 4, 6};
      tb = '{4, 5, 6, 7, 2, 3, 6, 7, 1, 3, 5, 7};
      tt = '{0, 1, 2, 3, 0, 2, 0, 2, 0, 0, 0, 0};
      i_bf_ready = 1'b1;
      start_run(3'd0);
      lat = 1; bi = 0;
      while (!o_done && lat < 200) begin
         if (o_bf_valid) begin
            checks++;
            if (bi >= 12) begin
               errors++; $display("FAIL cfg0_extra_beat: beat %0d required at most 12", bi);
            end else if ({o_stage, o_addr_a, o_addr_b, o_tw_idx} !== {4'(bi / 4), ta[bi], tb[bi], tt[bi]}) begin
               errors++;
               $display("FAIL cfg0_beat%0d: got s%0d (%0d,%0d) tw%0d required s%0d (%0d,%0d) tw%0d",
                        bi, o_stage, o_addr_a, o_addr_b, o_tw_idx, bi / 4, ta[bi], tb[bi], tt[bi]);
            end
            checks++;
            if (o_stage_start !== (bi % 4 == 0)) begin
               errors++; $display("FAIL cfg0_stage_start%0d: got %b required %b", bi, o_stage_start, bi % 4 == 0);
            end
            bi++;
         end
         tick(); lat++;
      end
      checks++;
      if (!o_done || lat != 31) begin
         errors++; $display("FAIL cfg0_latency: got %0d required 31", lat);
      end
      checks++;
      if (bi != 12) begin
         errors++; $display("FAIL cfg0_beats: got %0d required 12", bi);
      end
      tick();
      checks++;
      if (o_done !== 1'b0 || o_busy !== 1'b0) begin
         errors++; $display("FAIL cfg0_after_done: done %b busy %b required 0 0", o_done, o_busy);
      end
   endtask

   task automatic test_cfg7();
      int lat, total, s, j;
      i_bf_ready = 1'b1;
      start_run(3'd7);
      lat = 1; total = 0; s = 0; j = 0;
      while (!o_done && lat < 6000) begin
         if (o_bf_valid) begin
            checks++;
            if ({o_stage, o_addr_a, o_addr_b, o_tw_idx} !== exp_beat(7, s, j)) begin
               errors++;
               $display("FAIL cfg7_beat s%0d j%0d: got %h required %h", s, j,
                        {o_stage, o_addr_a, o_addr_b, o_tw_idx}, exp_beat(7, s, j));
            end
            if (s == 0 && j == 511) begin
               checks++;
               if (o_addr_a !== 10'd511 || o_addr_b !== 10'd1023 || o_tw_idx !== 9'd511) begin
                  errors++;
                  $display("FAIL cfg7_last_s0: got (%0d,%0d) tw%0d required (511,1023) tw511",
                           o_addr_a, o_addr_b, o_tw_idx);
               end
            end
            total++; j++;
            if (j == 512) begin j = 0; s++; end
         end
         tick(); lat++;
      end
      checks++;
      if (!o_done || lat != 5181) begin
         errors++; $display("FAIL cfg7_latency: got %0d required 5181", lat);
      end
      checks++;
      if (total != 5120) begin
         errors++; $display("FAIL cfg7_beats: got %0d required 5120", total);
      end
      tick();
   endtask

   task automatic test_random_ready();
      int lat, total, s, j, stalls, gap;
      logic in_gap, prev_stall;
      logic [32:0] cur, prev;
      start_run(3'd1);
      lat = 1; total = 0; s = 0; j = 0; stalls = 0; gap = 0;
      in_gap = 1'b0; prev_stall = 1'b0; prev = '0;
      while (!o_done && lat < 3000) begin
         i_bf_ready = 1'($urandom_range(0, 1));
         cur = {o_stage, o_addr_a, o_addr_b, o_tw_idx};
         if (prev_stall) begin
            checks++;
            if (!o_bf_valid || cur !== prev) begin
               errors++; $display("FAIL rand_stall_hold: got v%b %h required v1 %h", o_bf_valid, cur, prev);
            end
         end
         if (in_gap) begin
            if (o_bf_valid) begin
               checks++;
               if (gap != 6) begin
                  errors++; $display("FAIL rand_drain_gap: got %0d required 6", gap);
               end
               in_gap = 1'b0;
            end else begin
               gap++;
            end
         end
         if (o_bf_valid && i_bf_ready) begin
            checks++;
            if (cur !== exp_beat(1, s, j)) begin
               errors++; $display("FAIL rand_beat s%0d j%0d: got %h required %h", s, j, cur, exp_beat(1, s, j));
            end
            total++; j++;
            if (j == 8) begin j = 0; s++; in_gap = 1'b1; gap = 0; end
         end
         prev_stall = o_bf_valid && !i_bf_ready;
         if (prev_stall) stalls++;
         prev = cur;
         tick(); lat++;
      end
      checks++;
      if (!o_done || total != 32) begin
         errors++; $display("FAIL rand_beats: got %0d done %b required 32 done 1", total, o_done);
      end
      checks++;
      if (!in_gap || gap != 6) begin
         errors++; $display("FAIL rand_final_drain: got %0d required 6", gap);
      end
`ifdef NTT_SEQ_STALL_CNT_EN
      checks++;
      if (o_stall_cycles !== 16'(stalls)) begin
         errors++; $display("FAIL rand_stall_count: got %0d required %0d", o_stall_cycles, stalls);
      end
      tick(); tick();
      checks++;
      if (o_stall_cycles !== 16'(stalls)) begin
         errors++; $display("FAIL rand_stall_hold_after_done: got %0d required %0d", o_stall_cycles, stalls);
      end
`else
      tick(); tick();
`endif
   endtask

   task automatic test_start_ignored();
      int lat, bi;
      i_bf_ready = 1'b1;
      start_run(3'd0);
      lat = 1; bi = 0;
      while (!o_done && lat < 200) begin
         i_start = o_bf_valid && (bi == 2);
         checks++;
         if (o_busy !== 1'b1) begin
            errors++; $display("FAIL ign_busy: got %b required 1 at cycle %0d", o_busy, lat);
         end
         if (o_bf_valid) begin
            checks++;
            if ({o_stage, o_addr_a, o_addr_b, o_tw_idx} !== exp_beat(0, bi / 4, bi % 4)) begin
               errors++;
               $display("FAIL ign_beat%0d: got %h required %h", bi,
                        {o_stage, o_addr_a, o_addr_b, o_tw_idx}, exp_beat(0, bi / 4, bi % 4));
            end
            bi++;
         end
         tick(); lat++;
      end
      checks++;
      if (!o_done || lat != 31 || bi != 12) begin
         errors++; $display("FAIL ign_latency: got %0d cycles %0d beats required 31 12", lat, bi);
      end
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      tick();
      checks++;
      if (o_busy !== 1'b0 || o_bf_valid !== 1'b0) begin
         errors++; $display("FAIL ign_done_start: busy %b valid %b required 0 0", o_busy, o_bf_valid);
      end
   endtask

   task automatic test_reset_midrun();
      int lat, bi, s, j;
      logic bad;
      i_bf_ready = 1'b1;
      start_run(3'd3);
      lat = 1; bi = 0;
      while (bi < 69 && lat < 1000) begin
         if (o_bf_valid) bi++;
         tick(); lat++;
      end
      checks++;
      if (o_stage !== 4'd2 || o_bf_valid !== 1'b1) begin
         errors++; $display("FAIL mid_stage: got s%0d v%b required s2 v1", o_stage, o_bf_valid);
      end
      i_resetn = 1'b0;
      tick();
      i_resetn = 1'b1;
      checks++;
      if ({o_bf_valid, o_busy, o_done, o_stage_start, o_stage, o_addr_a, o_addr_b, o_tw_idx} !== '0) begin
         errors++;
         $display("FAIL mid_reset_outputs: got %h required 0",
                  {o_bf_valid, o_busy, o_done, o_stage_start, o_stage, o_addr_a, o_addr_b, o_tw_idx});
      end
`ifdef NTT_SEQ_STALL_CNT_EN
      checks++;
      if (o_stall_cycles !== 16'd0) begin
         errors++; $display("FAIL mid_reset_stall: got %0d required 0", o_stall_cycles);
      end
`endif
      bad = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         if (o_bf_valid !== 1'b0 || o_busy !== 1'b0) bad = 1'b1;
      end
      checks++;
      if (bad) begin
         errors++; $display("FAIL mid_no_beats_after_reset: got activity required none");
      end
      start_run(3'd2);
      lat = 1; bi = 0; s = 0; j = 0;
      while (!o_done && lat < 500) begin
         if (o_bf_valid) begin
            checks++;
            if ({o_stage, o_addr_a, o_addr_b, o_tw_idx} !== exp_beat(2, s, j)) begin
               errors++;
               $display("FAIL restart_beat s%0d j%0d: got %h required %h", s, j,
                        {o_stage, o_addr_a, o_addr_b, o_tw_idx}, exp_beat(2, s, j));
            end
            bi++; j++;
            if (j == 16) begin j = 0; s++; end
         end
         tick(); lat++;
      end
      checks++;
      if (!o_done || lat != 111 || bi != 80) begin
         errors++; $display("FAIL restart_latency: got %0d cycles %0d beats required 111 80", lat, bi);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      int lat;
      i_bf_ready = 1'b1;
      i_point_cfg = 3'd0;
      i_start = 1'b1;
      tick();
      lat = 1;
      while (!o_done && lat < 200) begin tick(); lat++; end
      checks++;
      if (!o_done || lat != 31) begin
         errors++; $display("FAIL b2b_first_latency: got %0d required 31", lat);
      end
      tick();
      checks++;
      if (o_busy !== 1'b0 || o_bf_valid !== 1'b0) begin
         errors++; $display("FAIL b2b_idle_gap: busy %b valid %b required 0 0", o_busy, o_bf_valid);
      end
      tick();
      checks++;
      if (o_stage_start !== 1'b1 || o_bf_valid !== 1'b1 || o_addr_a !== 10'd0 || o_addr_b !== 10'd4) begin
         errors++;
         $display("FAIL b2b_restart: got ss%b v%b (%0d,%0d) required ss1 v1 (0,4)",
                  o_stage_start, o_bf_valid, o_addr_a, o_addr_b);
      end
      lat = 1;
      while (!o_done && lat < 200) begin tick(); lat++; end
      checks++;
      if (!o_done || lat != 31) begin
         errors++; $display("FAIL b2b_second_latency: got %0d required 31", lat);
      end
      i_start = 1'b0;
      tick(); tick();
      checks++;
      if (o_busy !== 1'b0) begin
         errors++; $display("FAIL b2b_final_idle: busy %b required 0", o_busy);
      end
   endtask

   initial begin
      test_reset();
      test_cfg0();
      test_cfg7();
      test_random_ready();
      test_start_ignored();
      test_reset_midrun();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
